// File: rtl/transient_shaper_mc.sv
// Multichannel transient shaper: per-channel fast/slow envelope followers drive
// attack/sustain gain on a 3-stage valid/ready pipeline with output saturation.
module transient_shaper_mc #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NCH     = 2,
    parameter int unsigned FAST_SH = 2,
    parameter int unsigned SLOW_SH = 5,
    parameter int unsigned GAIN_W  = 4,
    localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]          in_ch,
    input  logic [GAIN_W-1:0]        attack_gain,
    input  logic signed [GAIN_W-1:0] sustain_gain,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     clip
);

    localparam int unsigned ENV_W = DATA_W + 1;
    localparam int unsigned DIF_W = DATA_W + 2;
    localparam int unsigned T_W   = DATA_W + 2;
    localparam int unsigned PRD_W = T_W + GAIN_W + 1;
    localparam int unsigned Y_W   = PRD_W + 2;

    localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic adv;

    // S1: captured sample, magnitude and gains
    logic                     s1_valid;
    logic                     s1_pass;
    logic signed [DATA_W-1:0] s1_data;
    logic [CH_W-1:0]          s1_ch;
    logic signed [ENV_W-1:0]  s1_abs;
    logic [GAIN_W-1:0]        s1_ag;
    logic signed [GAIN_W-1:0] s1_sg;

    // S2: envelope difference
    logic                     s2_valid;
    logic                     s2_pass;
    logic signed [DATA_W-1:0] s2_data;
    logic [CH_W-1:0]          s2_ch;
    logic signed [T_W-1:0]    s2_t;
    logic [GAIN_W-1:0]        s2_ag;
    logic signed [GAIN_W-1:0] s2_sg;

    logic signed [ENV_W-1:0] fast_env [NCH];
    logic signed [ENV_W-1:0] slow_env [NCH];

    logic signed [ENV_W-1:0]  in_abs_c;
    logic signed [ENV_W-1:0]  cur_fast;
    logic signed [ENV_W-1:0]  cur_slow;
    logic signed [DIF_W-1:0]  dif_fast;
    logic signed [DIF_W-1:0]  dif_slow;
    logic signed [ENV_W-1:0]  new_fast;
    logic signed [ENV_W-1:0]  new_slow;
    logic signed [T_W-1:0]    t_c;
    logic signed [T_W-1:0]    t_pos;
    logic signed [T_W-1:0]    t_neg;
    logic signed [PRD_W-1:0]  atk;
    logic signed [PRD_W-1:0]  sus;
    logic signed [Y_W-1:0]    mag;
    logic signed [Y_W-1:0]    y;
    logic signed [DATA_W-1:0] sat_data;
    logic                     sat_clip;

    assign adv      = en & (~out_valid | out_ready);
    assign in_ready = adv;

    // Magnitude with the most-negative code folded onto the positive maximum
    always_comb begin
        in_abs_c = ENV_W'(in_data);
        if (in_data[DATA_W-1]) begin
            in_abs_c = (in_data == D_MIN) ? ENV_W'(D_MAX) : -ENV_W'(in_data);
        end
    end

    // Envelope read-modify-write for the channel currently in S1
    always_comb begin
        cur_fast = '0;
        cur_slow = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (s1_ch == CH_W'(c)) begin
                cur_fast = fast_env[c];
                cur_slow = slow_env[c];
            end
        end
        dif_fast = DIF_W'(s1_abs) - DIF_W'(cur_fast);
        dif_slow = DIF_W'(s1_abs) - DIF_W'(cur_slow);
        new_fast = cur_fast + ENV_W'(dif_fast >>> FAST_SH);
        new_slow = cur_slow + ENV_W'(dif_slow >>> SLOW_SH);
        t_c      = T_W'(new_fast) - T_W'(new_slow);
    end

    // Gain application at full precision, then saturation
    always_comb begin
        t_pos    = s2_t[T_W-1] ? '0 : s2_t;
        t_neg    = s2_t[T_W-1] ? -s2_t : '0;
        atk      = (PRD_W'(t_pos) * PRD_W'($signed({1'b0, s2_ag}))) >>> 3;
        sus      = (PRD_W'(t_neg) * PRD_W'(s2_sg)) >>> 3;
        mag      = Y_W'(atk) + Y_W'(sus);
        y        = s2_data[DATA_W-1] ? (Y_W'(s2_data) - mag) : (Y_W'(s2_data) + mag);
        sat_data = DATA_W'(y);
        sat_clip = 1'b0;
        if (y > Y_W'(D_MAX)) begin
            sat_data = D_MAX;
            sat_clip = 1'b1;
        end else if (y < Y_W'(D_MIN)) begin
            sat_data = D_MIN;
            sat_clip = 1'b1;
        end
        if (s2_pass) begin
            sat_data = s2_data;
            sat_clip = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            clip      <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                fast_env[c] <= '0;
                slow_env[c] <= '0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_pass  <= 32'(in_ch) >= NCH;
            s1_data  <= in_data;
            s1_ch    <= in_ch;
            s1_abs   <= in_abs_c;
            s1_ag    <= attack_gain;
            s1_sg    <= sustain_gain;

            s2_valid <= s1_valid;
            s2_pass  <= s1_pass;
            s2_data  <= s1_data;
            s2_ch    <= s1_ch;
            s2_t     <= t_c;
            s2_ag    <= s1_ag;
            s2_sg    <= s1_sg;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (s1_valid && !s1_pass && s1_ch == CH_W'(c)) begin
                    fast_env[c] <= new_fast;
                    slow_env[c] <= new_slow;
                end
            end

            out_valid <= s2_valid;
            out_data  <= sat_data;
            out_ch    <= s2_ch;
            clip      <= s2_valid & sat_clip;
        end
    end

endmodule

// File: tb/tb_transient_shaper_mc.sv
// Scoreboard bench for transient_shaper_mc: directed cases plus randomized
// traffic checked against an arithmetic reference model.
module tb_transient_shaper_mc;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NCH     = 3;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned GAIN_W  = 4;
    localparam int unsigned FAST_SH = 2;
    localparam int unsigned SLOW_SH = 5;
    localparam longint DMAX = 32767;
    localparam longint DMIN = -32768;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic [CH_W-1:0]          in_ch;
    logic [GAIN_W-1:0]        attack_gain;
    logic signed [GAIN_W-1:0] sustain_gain;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     clip;

    transient_shaper_mc #(
        .DATA_W(DATA_W), .NCH(NCH), .FAST_SH(FAST_SH), .SLOW_SH(SLOW_SH), .GAIN_W(GAIN_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .attack_gain(attack_gain), .sustain_gain(sustain_gain),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .clip(clip)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint d;
        longint ch;
        longint clip;
    } exp_t;

    exp_t   q[$];
    longint fast_m [NCH];
    longint slow_m [NCH];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     n_out = 0;
    int     last_out_cyc = 0;
    int     last_acc_cyc = 0;
    longint last_d = 0;
    longint last_clip = 0;
    bit     rnd_on = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: envelope followers and gain law in plain integer arithmetic
    function automatic exp_t model(input longint d, input longint ch, input longint ag, input longint sg);
        exp_t   e;
        longint a, t, atk, sus, y;
        e.d = d;
        e.ch = ch;
        e.clip = 0;
        if (ch >= NCH) return e;
        a = (d >= 0) ? d : ((d == DMIN) ? DMAX : -d);
        fast_m[ch] = fast_m[ch] + ((a - fast_m[ch]) >>> FAST_SH);
        slow_m[ch] = slow_m[ch] + ((a - slow_m[ch]) >>> SLOW_SH);
        t   = fast_m[ch] - slow_m[ch];
        atk = (((t > 0) ? t : 0) * ag) >>> 3;
        sus = (((t < 0) ? -t : 0) * sg) >>> 3;
        y   = d + ((d >= 0) ? (atk + sus) : -(atk + sus));
        if (y > DMAX) begin
            e.d = DMAX;
            e.clip = 1;
        end else if (y < DMIN) begin
            e.d = DMIN;
            e.clip = 1;
        end else begin
            e.d = y;
        end
        return e;
    endfunction

    // Monitor: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            for (int c = 0; c < NCH; c++) begin
                fast_m[c] = 0;
                slow_m[c] = 0;
            end
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", longint'(out_data), e.d);
                    chk("out_ch", longint'(out_ch), e.ch);
                    chk("clip", longint'(clip), e.clip);
                end
                n_out++;
                last_d = longint'(out_data);
                last_clip = longint'(clip);
                last_out_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(longint'(in_data), longint'(in_ch),
                                  longint'(attack_gain), longint'(sustain_gain)));
                last_acc_cyc = cyc;
            end
        end
    end

    // Random backpressure and enable; downstream never takes data while disabled
    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            en = ($urandom_range(9) != 0);
            out_ready = en && ($urandom_range(9) < 7);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // All driver tasks start and end just after a rising edge
    task automatic send(input longint d, input int ch, input int ag, input int sg);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data = DATA_W'(d);
        in_ch = CH_W'(ch);
        attack_gain = GAIN_W'(ag);
        sustain_gain = GAIN_W'(sg);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        for (int i = 0; i < 100 && n_out < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_out < target) chk("out_timeout", n_out, target);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int     b;
        bit     ok;
        longint d;
        rst = 1'b1;
        en = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_ch = '0;
        attack_gain = '0;
        sustain_gain = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_clip", longint'(clip), 0);
        chk("reset_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Zero gains: pass-through value, three-cycle latency
        b = n_out;
        send(1024, 0, 0, 0);
        wait_out(b + 1);
        chk("unity_data", last_d, 1024);
        chk("unity_clip", last_clip, 0);
        chk("latency", longint'(last_out_cyc - last_acc_cyc), 3);

        do_reset();
        b = n_out;
        send(1024, 0, 8, 0);
        wait_out(b + 1);
        chk("attack_1024", last_d, 1248);

        // Saturation at both rails
        do_reset();
        b = n_out;
        send(32000, 0, 15, 0);
        wait_out(b + 1);
        chk("sat_pos_data", last_d, 32767);
        chk("sat_pos_clip", last_clip, 1);
        do_reset();
        b = n_out;
        send(-32768, 0, 15, 0);
        wait_out(b + 1);
        chk("sat_neg_data", last_d, -32768);
        chk("sat_neg_clip", last_clip, 1);

        // Channel isolation and out-of-range channel bypass
        do_reset();
        b = n_out;
        send(1024, 0, 8, 0);
        wait_out(b + 1);
        chk("iso_ch0", last_d, 1248);
        send(1024, 1, 8, 0);
        wait_out(b + 2);
        chk("iso_ch1", last_d, 1248);
        send(500, 3, 8, 0);
        wait_out(b + 3);
        chk("bypass_data", last_d, 500);
        chk("bypass_clip", last_clip, 0);

        // Stall with a full pipeline
        do_reset();
        b = n_out;
        out_ready = 1'b0;
        send(100, 0, 3, 2);
        send(-200, 1, 5, -3);
        send(300, 2, 7, 4);
        in_valid = 1'b1;
        in_data = 16'sd400;
        in_ch = 2'd0;
        attack_gain = 4'd6;
        sustain_gain = -4'sd1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stall_out_valid", longint'(out_valid), 1);
            chk("stall_in_ready", longint'(in_ready), 0);
            if (q.size() == 0) chk("stall_queue", 0, 1);
            else chk("stall_out_data", longint'(out_data), q[0].d);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("stall_release", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(b + 4);
        chk("stall_count", longint'(n_out - b), 4);

        // Reset with samples in flight
        do_reset();
        b = n_out;
        send(700, 0, 4, 1);
        send(-900, 1, 6, -2);
        send(1500, 2, 9, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_flush_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_no_emit", longint'(n_out - b), 0);
        send(1024, 0, 8, 0);
        wait_out(b + 1);
        chk("post_rst_data", last_d, 1248);

        // Enable low blocks intake
        en = 1'b0;
        @(negedge clk);
        chk("en_low_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        en = 1'b1;

        // Randomized traffic with backpressure and enable toggling
        rnd_on = 1'b1;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(2)) begin
                @(posedge clk);
                #1;
            end
            case ($urandom_range(3))
                0: d = longint'($urandom_range(65535)) - 32768;
                1: d = longint'($urandom_range(4000)) - 2000;
                2: begin
                    case ($urandom_range(3))
                        0: d = DMAX;
                        1: d = DMIN;
                        2: d = 0;
                        default: d = -1;
                    endcase
                end
                default: d = longint'($urandom_range(20000)) - 10000;
            endcase
            send(d, int'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(15)));
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", longint'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/transient_shaper_mc.md
TRANSIENT_SHAPER_MC -- requirements
Module: transient_shaper_mc

Interface
REQ-001 Parameter DATA_W, default 16, signed two's-complement sample width.
REQ-002 Parameter NCH, default 2, channel count; CH_W = max(1, clog2(NCH)).
REQ-003 Parameter FAST_SH, default 2, fast-envelope shift.
REQ-004 Parameter SLOW_SH, default 5, slow-envelope shift; SLOW_SH > FAST_SH.
REQ-005 Parameter GAIN_W, default 4, gain width.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 en  input  1  global enable; low freezes the pipeline.
REQ-009 in_valid  input  1  input sample offered.
REQ-010 in_ready  output  1  block accepts the sample this cycle.
REQ-011 in_data  input  DATA_W  signed sample.
REQ-012 in_ch  input  CH_W  channel tag of the sample.
REQ-013 attack_gain  input  GAIN_W  unsigned attack gain, units of 1/8.
REQ-014 sustain_gain  input  GAIN_W  signed sustain gain, units of 1/8; negative values cut sustain.
REQ-015 out_valid  output  1  output sample valid.
REQ-016 out_ready  input  1  downstream accepts the output.
REQ-017 out_data  output  DATA_W  shaped signed sample.
REQ-018 out_ch  output  CH_W  channel tag carried through.
REQ-019 clip  output  1  high with out_valid when out_data was saturated.

Function
REQ-020 Transfer on a port occurs when valid and ready are both high on the same rising edge.
REQ-021 Three pipeline stages S1 (capture, abs), S2 (envelope update), S3 (gain, saturate); the S3 register drives out_*.
REQ-022 adv = en & (!out_valid | out_ready); all stages advance only when adv is high; in_ready = adv.
REQ-023 Latency: an input accepted at edge N appears on out_* after edge N+3 when adv stays high; bubbles propagate as invalid stages.
REQ-024 attack_gain and sustain_gain are captured in S1 with the sample; later changes do not affect samples in flight.
REQ-025 a = |in_data|; most-negative input gives a = 2^(DATA_W-1)-1.
REQ-026 Per channel, signed envelopes of DATA_W+1 bits: fast' = fast + ((a - fast) >>> FAST_SH); slow' = slow + ((a - slow) >>> SLOW_SH).
REQ-027 Envelopes are read and written in S2 only, so back-to-back samples of the same channel see the updated value with no hazard.
REQ-028 t = fast' - slow'; atk = (max(t,0) * attack_gain) >>> 3; sus = (max(-t,0) * sustain_gain) >>> 3, signed, computed at full precision.
REQ-029 y = in_data + s*(atk + sus), s = +1 if in_data >= 0 else -1; full-precision intermediate with no truncation before saturation.
REQ-030 Saturation: y > 2^(DATA_W-1)-1 gives the maximum, y < -2^(DATA_W-1) gives the minimum; clip = 1 in either case, else 0.
REQ-031 in_ch >= NCH: sample passes unmodified (out_data = in_data, clip = 0) with normal latency; no envelope is touched.
REQ-032 While out_valid & !out_ready, out_data/out_ch/clip hold stable and in_ready = 0.
REQ-033 en low: in_ready = 0, all registers hold; out_valid keeps its value.

Reset
REQ-034 On rst: all envelopes = 0; all stage valids = 0; out_valid = 0, out_data = 0, out_ch = 0, clip = 0.
REQ-035 rst takes priority over en and handshakes; samples in flight mid-reset are discarded and never emerged.

Verification
REQ-036 Defaults after reset: ch0 in_data=1024, gains 0 -> out_data=1024, clip=0, out_valid 3 cycles later.
REQ-037 After reset: ch0 1024, attack_gain=8 -> fast'=256, slow'=32, t=224, out_data=1248.
REQ-038 After reset: ch0 32000, attack_gain=15 -> y=45125, out_data=32767, clip=1; then ch0 -32768, attack_gain=15, fresh reset -> out_data=-32768, clip=1.
REQ-039 Hold out_ready low 5 cycles with a full pipeline -> out_* stable, in_ready=0, no samples lost or duplicated after release.
REQ-040 Channel isolation: ch0 1024 (attack_gain=8) then ch1 1024 -> both out_data=1248; in_ch=3 (NCH=2) sample 500 -> out_data=500.
REQ-041 Assert rst with 3 samples in flight -> out_valid=0 the next cycle; next ch0 1024 with attack_gain=8 -> 1248.
